ram_stream_reader: RTL and testbench

RAM_STREAM_READER -- requirements
Module: ram_stream_reader

---
 rtl/ram_stream_reader_if.sv | 11 +
 rtl/ram_stream_reader.sv | 151 +++++++++++++++
 tb/tb_ram_stream_reader.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_stream_reader_if.sv
// Output stream bundle for ram_stream_reader: valid/ready word stream with
// a last-word marker. The master drives the words; the slave drives ready.
interface ram_stream_reader_if;
   logic        m_valid;
   logic        m_ready;
   logic [31:0] m_data;
   logic        m_last;

   modport master (output m_valid, output m_data, output m_last, input m_ready);
   modport slave  (input m_valid, input m_data, input m_last, output m_ready);
endinterface

// File: rtl/ram_stream_reader.sv
// ram_stream_reader: reads a burst of words from a synchronous-read RAM and
// streams them out through a small FIFO with valid/ready handshake.
// Reads are issued combinationally on ramAddress; the RAM returns data on
// rdData in the following cycle, which is pushed into the FIFO on that edge.
// Optional feature: define CHECKSUM_EN to add a 32-bit running sum of all
// transferred words on the checksum output.
module ram_stream_reader #(
   parameter int RAM_SIZE   = 1024,
   parameter int FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] base_addr,
   input  logic [31:0] length,
   output logic        busy,
   output logic        done,
   output logic [31:0] ramAddress,
   output logic        we,
   input  logic [31:0] rdData,
`ifdef CHECKSUM_EN
   output logic [31:0] checksum,
`endif
   ram_stream_reader_if.master m
);

   localparam int          PW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int          CW     = $clog2(FIFO_DEPTH + 1);
   localparam logic [31:0] RAM_SZ = 32'(RAM_SIZE);
   localparam logic [31:0] FDEPTH = 32'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t         r_state, w_state_nxt;
   logic [31:0]    r_len, r_idx, r_next_addr, r_addr_hold;
   logic           r_inflight, r_inf_last;
   logic [31:0]    r_mem_data [FIFO_DEPTH];
   logic           r_mem_last [FIFO_DEPTH];
   logic [PW-1:0]  r_wr_ptr, r_rd_ptr;
   logic [CW-1:0]  r_count;
   logic           w_issue, w_accept, w_push, w_pop, w_room, w_valid, w_last_idx;
   logic [31:0]    w_occ;

   // A word arriving on rdData this cycle is always pushed; a pop frees a
   // slot in the same cycle, which keeps the stream at one word per cycle.
   assign w_valid    = (r_count != '0);
   assign w_pop      = w_valid & m.m_ready;
   assign w_push     = r_inflight;
   assign w_occ      = 32'(r_count) + {31'b0, r_inflight} - {31'b0, w_pop};
   assign w_room     = (w_occ < FDEPTH);
   assign w_last_idx = (r_idx == r_len - 32'd1);

   assign m.m_valid  = w_valid;
   assign m.m_data   = w_valid ? r_mem_data[r_rd_ptr] : 32'd0;
   assign m.m_last   = w_valid ? r_mem_last[r_rd_ptr] : 1'b0;
   assign ramAddress = w_issue ? r_next_addr : r_addr_hold;
   assign we         = 1'b0;

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // FSM next state, read issue and status outputs
   always_comb begin
      w_state_nxt = r_state;
      w_issue     = 1'b0;
      w_accept    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_accept    = 1'b1;
               w_state_nxt = (length == 32'd0) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            if (w_room) begin
               w_issue = 1'b1;
               if (w_last_idx) w_state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            // Leave once the last buffered word is being taken this cycle.
            if (!r_inflight && (r_count == CW'(w_pop))) w_state_nxt = S_DONE;
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
      busy = (r_state == S_RUN) || (r_state == S_DRAIN) || (w_accept && !rst);
      done = (r_state == S_DONE);
   end

   // Burst parameters, issue counter, address generation, read tracking
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_len       <= '0;
         r_idx       <= '0;
         r_next_addr <= '0;
         r_addr_hold <= '0;
         r_inflight  <= 1'b0;
         r_inf_last  <= 1'b0;
      end else begin
         if (w_accept) begin
            r_len       <= length;
            r_idx       <= '0;
            r_next_addr <= base_addr % RAM_SZ;
         end else if (w_issue) begin
            r_idx       <= r_idx + 32'd1;
            r_next_addr <= (r_next_addr == RAM_SZ - 32'd1) ? 32'd0 : r_next_addr + 32'd1;
            r_addr_hold <= r_next_addr;
         end
         r_inflight <= w_issue;
         r_inf_last <= w_issue && w_last_idx;
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= (r_wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
         if (w_pop)  r_rd_ptr <= (r_rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

   // FIFO storage; contents are masked at the output while empty
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_data[r_wr_ptr] <= rdData;
         r_mem_last[r_wr_ptr] <= r_inf_last;
      end
   end

`ifdef CHECKSUM_EN
   logic [31:0] r_sum;
   assign checksum = r_sum;

   // Running sum of transferred words, restarted on each accepted start
   always_ff @(posedge clk or posedge rst) begin
      if (rst)           r_sum <= '0;
      else if (w_accept) r_sum <= '0;
      else if (w_pop)    r_sum <= r_sum + m.m_data;
   end
`endif

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader: burst timing, address wrap, stalls,
// zero-length burst, mid-burst reset and (with CHECKSUM_EN) the checksum.
module tb_ram_stream_reader;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [31:0] base_addr = '0;
   logic [31:0] length = '0;
   logic        busy, done, we;
   logic [31:0] ramAddress;
   logic [31:0] rdData = '0;
`ifdef CHECKSUM_EN
   logic [31:0] checksum;
`endif

   int total = 0;
   int bad   = 0;

   logic [31:0] mem [1024];
   logic [31:0] q_data [$];
   logic        q_last [$];

   ram_stream_reader_if sif ();

   ram_stream_reader #(.RAM_SIZE(1024), .FIFO_DEPTH(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .base_addr  (base_addr),
      .length     (length),
      .busy       (busy),
      .done       (done),
      .ramAddress (ramAddress),
      .we         (we),
      .rdData     (rdData),
`ifdef CHECKSUM_EN
      .checksum   (checksum),
`endif
      .m          (sif)
   );

   always #5 clk = ~clk;

   // synchronous-read RAM model: data one cycle after the address
   always @(posedge clk) rdData <= mem[ramAddress[9:0]];

   // transfer monitor
   always @(posedge clk) begin
      if (!rst && sif.m_valid && sif.m_ready) begin
         q_data.push_back(sif.m_data);
         q_last.push_back(sif.m_last);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (done !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_done"}, {31'b0, done}, 32'd1);
   endtask

   initial begin
      logic pv, pr, pl;
      logic [31:0] pd;
      logic [3:0] rpat;
      bit saw_done;
      int n;

      for (int k = 0; k < 1024; k++) mem[k] = 32'h100 + k;
      sif.m_ready = 1'b1;

      // ---- reset state
      #12;
      check("rst_busy", {31'b0, busy}, 0);
      check("rst_done", {31'b0, done}, 0);
      check("rst_valid", {31'b0, sif.m_valid}, 0);
      check("rst_last", {31'b0, sif.m_last}, 0);
      check("rst_data", sif.m_data, 0);
      check("rst_addr", ramAddress, 0);
      check("rst_we", {31'b0, we}, 0);
`ifdef CHECKSUM_EN
      check("rst_csum", checksum, 0);
`endif
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // ---- burst base=4 len=5, ignored start while busy
      q_data.delete(); q_last.delete();
      start = 1'b1; base_addr = 4; length = 5;
      @(negedge clk);                                 // C0
      check("t1_busy", {31'b0, busy}, 1);
      check("t1_addr0", ramAddress, 4);
      check("t1_v0", {31'b0, sif.m_valid}, 0);
      start = 1'b0;
      @(negedge clk);                                 // C1
      check("t1_v1", {31'b0, sif.m_valid}, 0);
      check("t1_addr1", ramAddress, 5);
      for (int i = 0; i < 5; i++) begin              // C2..C6
         @(negedge clk);
         check("t1_valid", {31'b0, sif.m_valid}, 1);
         check("t1_data", sif.m_data, 32'h104 + i);
         check("t1_last", {31'b0, sif.m_last}, (i == 4) ? 1 : 0);
         check("t1_nodone", {31'b0, done}, 0);
         if (i == 1) begin start = 1'b1; base_addr = 100; length = 9; end
         if (i == 2) start = 1'b0;
      end
      @(negedge clk);                                 // C7
      check("t1_done", {31'b0, done}, 1);
      check("t1_busy_off", {31'b0, busy}, 0);
      check("t1_v_end", {31'b0, sif.m_valid}, 0);
      @(negedge clk);
      check("t1_done_pulse", {31'b0, done}, 0);
      check("t1_count", q_data.size(), 5);

      // ---- address wrap: base=1022 len=4
      start = 1'b1; base_addr = 1022; length = 4;
      @(negedge clk);                                 // C0
      check("t2_a0", ramAddress, 1022);
      start = 1'b0;
      @(negedge clk);                                 // C1
      check("t2_a1", ramAddress, 1023);
      @(negedge clk);                                 // C2
      check("t2_a2", ramAddress, 0);
      check("t2_d0", sif.m_data, 32'h4FE);
      @(negedge clk);                                 // C3
      check("t2_a3", ramAddress, 1);
      check("t2_d1", sif.m_data, 32'h4FF);
      @(negedge clk);                                 // C4
      check("t2_hold", ramAddress, 1);
      check("t2_d2", sif.m_data, 32'h100);
      @(negedge clk);                                 // C5
      check("t2_d3", sif.m_data, 32'h101);
      check("t2_last", {31'b0, sif.m_last}, 1);
      @(negedge clk);                                 // C6
      check("t2_done", {31'b0, done}, 1);
      @(negedge clk);

      // ---- stalls: len=8, ready pattern 1,0,0,1
      q_data.delete(); q_last.delete();
      rpat = 4'b1001;
      start = 1'b1; base_addr = 40; length = 8;
      pv = 1'b0; pr = 1'b1; pd = '0; pl = 1'b0;
      saw_done = 1'b0;
      n = 0;
      while (!saw_done && n < 100) begin
         @(negedge clk);
         start = 1'b0;
         if (pv && !pr) begin
            check("t3_stall_v", {31'b0, sif.m_valid}, 1);
            check("t3_stall_d", sif.m_data, pd);
            check("t3_stall_l", {31'b0, sif.m_last}, {31'b0, pl});
         end
         if (done) saw_done = 1'b1;
         sif.m_ready = rpat[n % 4];
         pv = sif.m_valid; pr = sif.m_ready; pd = sif.m_data; pl = sif.m_last;
         n++;
      end
      check("t3_done", {31'b0, saw_done}, 1);
      sif.m_ready = 1'b1;
      check("t3_count", q_data.size(), 8);
      for (int i = 0; i < 8 && i < q_data.size(); i++) begin
         check("t3_data", q_data[i], 32'h100 + 40 + i);
         check("t3_last", {31'b0, q_last[i]}, (i == 7) ? 1 : 0);
      end
      @(negedge clk);

      // ---- zero length
      start = 1'b1; base_addr = 7; length = 0;
      #1;
      check("t4_busy", {31'b0, busy}, 1);
      @(negedge clk);
      start = 1'b0;
      check("t4_done", {31'b0, done}, 1);
      check("t4_busy_off", {31'b0, busy}, 0);
      check("t4_valid", {31'b0, sif.m_valid}, 0);
      @(negedge clk);
      check("t4_pulse", {31'b0, done}, 0);
      check("t4_valid2", {31'b0, sif.m_valid}, 0);

      // ---- reset after 3 words of a 10-word burst
      q_data.delete(); q_last.delete();
      start = 1'b1; base_addr = 0; length = 10;
      n = 0;
      @(negedge clk);
      start = 1'b0;
      while (q_data.size() < 3 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("t5_three", q_data.size(), 3);
      rst = 1'b1;
      #1;
      check("t5_valid", {31'b0, sif.m_valid}, 0);
      check("t5_data", sif.m_data, 0);
      check("t5_last", {31'b0, sif.m_last}, 0);
      check("t5_busy", {31'b0, busy}, 0);
      check("t5_addr", ramAddress, 0);
      saw_done = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (done) saw_done = 1'b1;
      end
      rst = 1'b0;
      @(negedge clk);
      if (done || sif.m_valid) saw_done = 1'b1;
      check("t5_no_done", {31'b0, saw_done}, 0);
      q_data.delete(); q_last.delete();
      start = 1'b1; base_addr = 20; length = 2;
      @(negedge clk);
      start = 1'b0;
      wait_done("t5b");
      check("t5b_count", q_data.size(), 2);
      if (q_data.size() == 2) begin
         check("t5b_d0", q_data[0], 32'h114);
         check("t5b_d1", q_data[1], 32'h115);
         check("t5b_l0", {31'b0, q_last[0]}, 0);
         check("t5b_l1", {31'b0, q_last[1]}, 1);
      end
      @(negedge clk);

`ifdef CHECKSUM_EN
      // ---- checksum wraps mod 2^32
      mem[50] = 32'h1; mem[51] = 32'h2; mem[52] = 32'hFFFF_FFFF;
      start = 1'b1; base_addr = 50; length = 3;
      @(negedge clk);
      start = 1'b0;
      wait_done("t6");
      check("t6_csum", checksum, 32'h2);
      @(negedge clk);
      check("t6_hold", checksum, 32'h2);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
